// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory command port arbiter.
//   state_e        : arbiter FSM state encodings
//   DEFAULT_WIDTH  : default command/instruction word width
//   REQ_DEC/FETCH  : requester ids used for grant_id
package mem_port_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic REQ_DEC   = 1'b0;
  localparam logic REQ_FETCH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_RELEASE = 2'b10
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
//   req[1:0] : request vector
//   ptr      : id favoured when both requesters are active
//   valid    : at least one request present
//   id       : selected requester
module mem_port_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    // Contention resolves to the pointer; otherwise the lone requester wins.
    id    = (req == 2'b11) ? ptr : req[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory command port between the decoder (req0)
// and the fetch unit (req1) with round-robin priority and a watchdog.
//   clk, reset            : clock, async active-low reset
//   req0_* / req1_*       : requester start/data in, one-cycle ready out
//   mem_start/data/ready  : memory command handshake
//   grant_id, busy        : current grant, high in BUSY and RELEASE
//   timeout_err           : sticky watchdog flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_start,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_start,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             mem_start,
  output logic [WIDTH-1:0] mem_data,
  input  logic             mem_ready,
  output logic             grant_id,
  output logic             busy,
  output logic             timeout_err
);

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic               mem_start_q, mem_start_d;
  logic [WIDTH-1:0]   mem_data_q, mem_data_d;
  logic               grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic [1:0]         ready_q, ready_d;
  logic               timeout_err_q, timeout_err_d;

  logic               pick_valid;
  logic               pick_id;
  logic               wd_expire;

  mem_port_arbiter_rr_pick2 u_pick (
    .req   ({req1_start, req0_start}),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  // Watchdog fires on the last allowed BUSY cycle; TIMEOUT of 0 disables it.
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    mem_start_d   = mem_start_q;
    mem_data_d    = mem_data_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    ready_d       = 2'b00;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          mem_data_d  = (pick_id == REQ_FETCH) ? req1_data : req0_data;
          grant_id_d  = pick_id;
          mem_start_d = 1'b1;
          busy_d      = 1'b1;
          wd_cnt_d    = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
        if (mem_ready || wd_expire) begin
          mem_start_d         = 1'b0;
          ready_d[grant_id_q] = 1'b1;
          rr_ptr_d            = ~grant_id_q;
          state_d             = ST_RELEASE;
          // A real completion in the expiry cycle wins over the watchdog.
          if (!mem_ready) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= REQ_DEC;
      wd_cnt_q      <= '0;
      mem_start_q   <= 1'b0;
      mem_data_q    <= '0;
      grant_id_q    <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 2'b00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
      mem_start_q   <= mem_start_d;
      mem_data_q    <= mem_data_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req0_ready  = ready_q[0];
  assign req1_ready  = ready_q[1];
  assign mem_start   = mem_start_q;
  assign mem_data    = mem_data_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT=4).
// Reference: transaction-level model of round-robin winner, expected
// mem_start duration, ready pulse target and sticky timeout flag.
module tb_mem_port_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_start, req1_start;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             mem_start;
  logic [WIDTH-1:0] mem_data;
  logic             mem_ready;
  logic             grant_id;
  logic             busy;
  logic             timeout_err;

  int errors = 0;
  int checks = 0;

  // Model state: who is favoured on contention, and the sticky error flag.
  logic m_ptr;
  logic m_terr;

  mem_port_arbiter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_start  (req0_start),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_start  (req1_start),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .mem_start   (mem_start),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0_start = 1'b0; req1_start = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_ptr = 1'b0;
    m_terr = 1'b0;
  endtask

  task automatic test_reset();
    req0_start = 1'b0; req1_start = 1'b0; mem_ready = 1'b0;
    req0_data = '0; req1_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    checks++;
    if ({mem_start, busy, grant_id, req0_ready, req1_ready, timeout_err} !== 6'b0 ||
        mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b busy=%b gid=%b r0=%b r1=%b terr=%b data=%h expected all 0",
               mem_start, busy, grant_id, req0_ready, req1_ready, timeout_err, mem_data);
    end
    tick();
    reset = 1'b1;
    m_ptr = 1'b0;
    m_terr = 1'b0;
  endtask

  task automatic test_single();
    int r0_pulses;
    req0_data = 32'h920104E0;
    req0_start = 1'b1;
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_data !== 32'h920104E0 || grant_id !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got start=%b data=%h gid=%b busy=%b expected 1 920104e0 0 1",
               mem_start, mem_data, grant_id, busy);
    end
    r0_pulses = 0;
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req0_start = 1'b0;
    if (req0_ready === 1'b1) r0_pulses++;
    checks++;
    if (mem_start !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_complete: got start=%b r0=%b r1=%b busy=%b expected 0 1 0 1",
               mem_start, req0_ready, req1_ready, busy);
    end
    tick();
    if (req0_ready === 1'b1) r0_pulses++;
    checks++;
    if (busy !== 1'b0 || r0_pulses != 1) begin
      errors++;
      $display("FAIL single_release: got busy=%b pulses=%0d expected 0 1", busy, r0_pulses);
    end
    m_ptr = 1'b1;
  endtask

  task automatic test_alternate();
    logic [WIDTH-1:0] d [2];
    logic exp_id;
    do_reset();
    d[0] = $urandom;
    d[1] = $urandom ^ 32'h5A5A_0001;
    req0_data = d[0]; req1_data = d[1];
    req0_start = 1'b1; req1_start = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_id = m_ptr;
      tick();
      checks++;
      if (mem_start !== 1'b1 || grant_id !== exp_id || mem_data !== d[exp_id]) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got start=%b gid=%b data=%h expected 1 %b %h",
                 t, mem_start, grant_id, mem_data, exp_id, d[exp_id]);
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01) || mem_start !== 1'b0) begin
        errors++;
        $display("FAIL alt_ready[%0d]: got r1r0=%b start=%b expected %b 0",
                 t, {req1_ready, req0_ready}, mem_start, (exp_id ? 2'b10 : 2'b01));
      end
      tick();
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL alt_release[%0d]: got r1r0=%b busy=%b expected 00 0",
                 t, {req1_ready, req0_ready}, busy);
      end
      m_ptr = ~exp_id;
    end
    req0_start = 1'b0; req1_start = 1'b0;
  endtask

  task automatic test_timeout();
    int hi;
    req1_data = $urandom;
    req1_start = 1'b1;
    mem_ready = 1'b0;
    tick();
    hi = 0;
    while (mem_start === 1'b1 && hi < 12) begin
      hi++;
      tick();
    end
    m_terr = 1'b1;
    checks++;
    if (hi != TIMEOUT || req1_ready !== 1'b1 || req0_ready !== 1'b0 || timeout_err !== m_terr) begin
      errors++;
      $display("FAIL timeout_abort: got hi=%0d r1=%b r0=%b terr=%b expected %0d 1 0 1",
               hi, req1_ready, req0_ready, timeout_err, TIMEOUT);
    end
    req1_start = 1'b0;
    m_ptr = 1'b0;
    tick();
    req0_data = $urandom;
    req0_start = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req0_start = 1'b0;
    checks++;
    if (req0_ready !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got r0=%b terr=%b expected 1 1", req0_ready, timeout_err);
    end
    m_ptr = 1'b1;
    tick();
  endtask

  task automatic test_coincide();
    do_reset();
    req0_data = $urandom;
    req0_start = 1'b1;
    tick();
    for (int i = 1; i < TIMEOUT; i++) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req0_start = 1'b0;
    checks++;
    if (req0_ready !== 1'b1 || timeout_err !== 1'b0 || mem_start !== 1'b0) begin
      errors++;
      $display("FAIL coincide: got r0=%b terr=%b start=%b expected 1 0 0",
               req0_ready, timeout_err, mem_start);
    end
    m_ptr = 1'b1;
    tick();
  endtask

  task automatic test_drop_start();
    logic [WIDTH-1:0] orig;
    orig = $urandom;
    req1_data = orig;
    req1_start = 1'b1;
    tick();
    tick();
    req1_start = 1'b0;
    req1_data = ~orig;
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_data !== orig || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL drop_hold: got start=%b data=%h gid=%b expected 1 %h 1",
               mem_start, mem_data, grant_id, orig);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready: got r1=%b r0=%b expected 1 0", req1_ready, req0_ready);
    end
    m_ptr = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int pulses;
    // Serve req0 first so the pointer favours req1 before the reset.
    req0_start = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req0_start = 1'b0;
    tick();
    req1_data = $urandom;
    req1_start = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_start !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got start=%b busy=%b gid=%b expected 0 0 0",
               mem_start, busy, grant_id);
    end
    req1_start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (req0_ready === 1'b1 || req1_ready === 1'b1) pulses++;
    end
    reset = 1'b1;
    m_ptr = 1'b0;
    m_terr = 1'b0;
    tick();
    if (req0_ready === 1'b1 || req1_ready === 1'b1) pulses++;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL async_no_ready: got %0d ready pulses expected 0", pulses);
    end
    req0_start = 1'b1; req1_start = 1'b1;
    tick();
    checks++;
    if (grant_id !== m_ptr || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_ptr: got gid=%b busy=%b expected %b 1", grant_id, busy, m_ptr);
    end
    req0_start = 1'b0; req1_start = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    m_ptr = 1'b1;
    tick();
  endtask

  task automatic test_stray_ready();
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_start !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready: got busy=%b start=%b r0=%b r1=%b expected 0 0 0 0",
               busy, mem_start, req0_ready, req1_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0] who;
    logic       win;
    int         lat, exp_hi, hi;
    logic [WIDTH-1:0] d0, d1, exp_data;
    for (int t = 0; t < 40; t++) begin
      who = 2'($urandom_range(1, 3));
      lat = $urandom_range(1, 6);
      d0 = $urandom; d1 = $urandom;
      win = (who == 2'b11) ? m_ptr : who[1];
      exp_data = win ? d1 : d0;
      exp_hi = (lat < int'(TIMEOUT)) ? lat : int'(TIMEOUT);
      if (lat > int'(TIMEOUT)) m_terr = 1'b1;
      req0_data = d0; req1_data = d1;
      req0_start = who[0]; req1_start = who[1];
      tick();
      checks++;
      if (grant_id !== win || mem_data !== exp_data || mem_start !== 1'b1) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got gid=%b data=%h start=%b expected %b %h 1",
                 t, grant_id, mem_data, mem_start, win, exp_data);
      end
      hi = 1;
      forever begin
        if (hi == lat) mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        if (mem_start !== 1'b1 || hi > 20) break;
        hi++;
      end
      req0_start = 1'b0; req1_start = 1'b0;
      checks++;
      if (hi != exp_hi || {req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01) ||
          timeout_err !== m_terr) begin
        errors++;
        $display("FAIL rand_done[%0d]: got hi=%0d r1r0=%b terr=%b expected %0d %b %b",
                 t, hi, {req1_ready, req0_ready}, timeout_err, exp_hi,
                 (win ? 2'b10 : 2'b01), m_terr);
      end
      m_ptr = ~win;
      tick();
      checks++;
      if (busy !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL rand_release[%0d]: got busy=%b r1r0=%b expected 0 00",
                 t, busy, {req1_ready, req0_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_coincide();
    test_drop_start();
    test_async_reset();
    test_stray_ready();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
